// File: rtl/patch_fetch_unit.sv
// Patch fetch unit: walks a (2pr+1)x(2pc+1) window of a row-major image
// and captures each pixel (zero-padded outside the image) into a FIFO.
module patch_fetch_unit #(
  parameter int pr         = 16,
  parameter int pc         = 16,
  parameter int rows       = 436,
  parameter int cols       = 1024,
  parameter int imbits     = 19,
  parameter int DEPTH      = 2048,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  addr_en,
  input  logic                  col_count_en,
  input  logic [imbits-1:0]     start_address,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  r_en,
  output logic [imbits-1:0]     addr,
  output logic                  row_done,
  output logic                  patch_done,
  output logic                  invalid_addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(2 * pc + 2);
  localparam int RW = $clog2(2 * pr + 2);
  localparam int SW = imbits + 1;

  localparam logic [CW-1:0] CMAX = CW'(2 * pc);
  localparam logic [RW-1:0] RMAX = RW'(2 * pr);
  localparam logic [SW-1:0] LIM  = SW'(rows * cols);
  localparam logic [SW-1:0] STEP = SW'(cols);

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [SW-1:0] row_base;
  logic [SW-1:0] sum;
  logic          advance;
  logic          col_last;
  logic          row_last;

  assign col_last = (col_cnt == CMAX);
  assign row_last = (row_cnt == RMAX);
  assign advance  = addr_en & col_count_en & ~patch_done;

  // Extra MSB keeps addresses past the image end distinguishable.
  assign sum = {1'b0, start_address} + row_base
             + {{(SW - CW){1'b0}}, col_cnt};

  assign addr         = sum[imbits-1:0];
  assign invalid_addr = (sum >= LIM);
  assign row_done     = col_last & addr_en;

  always_ff @(posedge clk) begin
    if (reset || !addr_en) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      row_base   <= '0;
      patch_done <= 1'b0;
    end else if (advance) begin
      if (!col_last) begin
        col_cnt <= col_cnt + 1'b1;
      end else if (row_last) begin
        patch_done <= 1'b1;
      end else begin
        col_cnt  <= '0;
        row_cnt  <= row_cnt + 1'b1;
        row_base <= row_base + STEP;
      end
    end
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wptr;
  logic [AW:0]           rptr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] wdata;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW])
               && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign wr_ok = advance & ~full;
  assign rd_ok = r_en & ~empty;
  assign wdata = invalid_addr ? '0 : pixel_in;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      data_out <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr     <= rptr + 1'b1;
        data_out <= mem[rptr[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_patch_fetch_unit.sv
// Randomized scoreboard bench for patch_fetch_unit: a full-size instance
// for address generation and a small-FIFO instance for FIFO boundaries.
module tb_patch_fetch_unit;

  localparam int COLS = 1024;
  localparam int LIM  = 436 * 1024;
  localparam int W    = 33;
  localparam int NPIX = 33 * 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        addr_en, col_count_en, r_en;
  logic [18:0] start_address;
  logic [7:0]  pixel_in;
  logic [18:0] addr;
  logic        row_done, patch_done, invalid_addr, full, empty;
  logic [7:0]  data_out;

  logic        addr_en2, cen2, r_en2;
  logic [5:0]  start2;
  logic [7:0]  pixel2;
  logic [5:0]  addr2;
  logic        row_done2, patch_done2, invalid2, full2, empty2;
  logic [7:0]  data_out2;

  int nvec = 0;
  int nerr = 0;
  int q[$];
  int q2[$];
  bit rd_go = 0;

  always #5 clk = ~clk;

  function automatic int pix(input int a);
    return ((a * 7) ^ (a >> 8) ^ (a >> 3)) & 255;
  endfunction

  assign pixel_in = 8'(pix(int'(addr)));
  assign pixel2   = 8'(pix(int'(addr2)));

  patch_fetch_unit u_big (
    .clk(clk), .reset(reset), .addr_en(addr_en),
    .col_count_en(col_count_en), .start_address(start_address),
    .pixel_in(pixel_in), .r_en(r_en), .addr(addr),
    .row_done(row_done), .patch_done(patch_done),
    .invalid_addr(invalid_addr), .data_out(data_out),
    .full(full), .empty(empty)
  );

  patch_fetch_unit #(
    .pr(1), .pc(1), .rows(8), .cols(8), .imbits(6),
    .DEPTH(16), .DATA_WIDTH(8)
  ) u_small (
    .clk(clk), .reset(reset), .addr_en(addr_en2),
    .col_count_en(cen2), .start_address(start2),
    .pixel_in(pixel2), .r_en(r_en2), .addr(addr2),
    .row_done(row_done2), .patch_done(patch_done2),
    .invalid_addr(invalid2), .data_out(data_out2),
    .full(full2), .empty(empty2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitors: pop the expected value whenever the DUT accepts a read.
  initial forever begin
    bit fire;
    @(posedge clk);
    fire = r_en && !empty && !reset;
    #1;
    if (fire) begin
      if (q.size() == 0) chk("big_extra_read", int'(data_out), -1);
      else chk("big_data", int'(data_out), q.pop_front());
    end
  end

  initial forever begin
    bit fire;
    @(posedge clk);
    fire = r_en2 && !empty2 && !reset;
    #1;
    if (fire) begin
      if (q2.size() == 0) chk("small_extra_read", int'(data_out2), -1);
      else chk("small_data", int'(data_out2), q2.pop_front());
    end
  end

  initial forever begin
    @(negedge clk);
    r_en = rd_go && ($urandom_range(0, 1) == 1);
  end

  task automatic run_patch(input int st, input bit stall);
    int k, a, guard;
    for (int n = 0; n < NPIX; n++) begin
      a = st + (n / W) * COLS + (n % W);
      q.push_back(a >= LIM ? 0 : pix(a));
    end
    k = 0;
    guard = 0;
    col_count_en = 1'b0;
    start_address = 19'(st);
    addr_en = 1'b1;
    while (k < NPIX && guard < 20000) begin
      @(negedge clk);
      col_count_en = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      a = st + (k / W) * COLS + (k % W);
      chk("addr", int'(addr), a);
      chk("row_done", int'(row_done), int'((k % W) == W - 1));
      chk("invalid_addr", int'(invalid_addr), int'(a >= LIM));
      chk("patch_done_low", int'(patch_done), 0);
      @(posedge clk);
      if (col_count_en) k++;
      guard++;
    end
    chk("patch_timeout", guard < 20000 ? 1 : 0, 1);
    @(negedge clk);
    #1;
    chk("patch_done_high", int'(patch_done), 1);
    chk("last_addr", int'(addr), st + (W - 1) * COLS + (W - 1));
  endtask

  task automatic rearm();
    @(negedge clk);
    addr_en = 1'b0;
    @(negedge clk);
    #1;
    chk("rearm_done_clear", int'(patch_done), 0);
  endtask

  task automatic small_patch(input int st);
    @(negedge clk);
    start2 = 6'(st);
    addr_en2 = 1'b1;
    cen2 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      int a;
      a = st + (i / 3) * 8 + (i % 3);
      if (q2.size() < 16) q2.push_back(pix(a));
    end
    repeat (11) @(negedge clk);
    #1;
    chk("small_patch_done", int'(patch_done2), 1);
    addr_en2 = 1'b0;
    cen2 = 1'b0;
  endtask

  initial begin
    int guard;
    logic [7:0] held;
    reset = 1'b1;
    addr_en = 1'b0;
    col_count_en = 1'b0;
    start_address = 19'h100;
    addr_en2 = 1'b0;
    cen2 = 1'b0;
    r_en2 = 1'b0;
    start2 = '0;
    r_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_addr", int'(addr), 'h100);
    chk("rst_patch_done", int'(patch_done), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_data_out", int'(data_out), 0);
    reset = 1'b0;
    rd_go = 1;

    run_patch(101 * 1024 + 179, 1'b0);
    chk("interior_last", int'(addr), 136403);
    rearm();
    run_patch(184 * 1024 + 484, 1'b1);
    rearm();
    run_patch(430 * 1024 + 100, 1'b0);

    guard = 0;
    while (q.size() != 0 && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", q.size(), 0);
    @(negedge clk);
    #1;
    chk("big_empty_end", int'(empty), 1);
    rd_go = 0;

    small_patch(9);
    @(negedge clk);
    small_patch(27);
    #1;
    chk("small_full", int'(full2), 1);
    chk("small_not_empty", int'(empty2), 0);
    chk("small_model_16", q2.size(), 16);
    @(negedge clk);
    r_en2 = 1'b1;
    repeat (16) @(negedge clk);
    r_en2 = 1'b0;
    #1;
    chk("small_empty", int'(empty2), 1);
    chk("small_not_full", int'(full2), 0);
    chk("small_all_read", q2.size(), 0);
    held = data_out2;
    @(negedge clk);
    r_en2 = 1'b1;
    @(negedge clk);
    r_en2 = 1'b0;
    #1;
    chk("small_empty_read_hold", int'(data_out2), int'(held));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/patch_fetch_unit.md
# patch_fetch_unit

Patch fetch unit for the pyramidal Lucas-Kanade datapath: an address generator (`address_gen` function) walks a (2·pr+1)×(2·pc+1) window of a row-major image and captures each fetched pixel into an internal synchronous FIFO (`sync_fifo` function). Downstream interpolation/gradient logic drains the FIFO. The image memory is external; it returns `pixel_in` combinationally for `addr`.

## Interface
- `pr`, 16: patch half-height; the patch has 2·pr+1 rows.
- `pc`, 16: patch half-width; the patch has 2·pc+1 columns.
- `rows`, 436: image height in pixels.
- `cols`, 1024: image width in pixels.
- `imbits`, 19: address width; must satisfy 2^imbits ≥ rows·cols.
- `DEPTH`, 2048: FIFO depth; power of two, ≥ (2pr+1)(2pc+1).
- `DATA_WIDTH`, 8: pixel width.

Clocking: one clock; reset is synchronous and active-high.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `addr_en`  in  1  enable; low holds the generator idle and re-arms it.
- `col_count_en`  in  1  advance enable for the column counter.
- `start_address`  in  imbits  top-left pixel address, (r−pr)·cols+(c−pc).
- `pixel_in`  in  DATA_WIDTH  image data at `addr`, same cycle.
- `r_en`  in  1  FIFO read request.
- `addr`  out  imbits  current pixel address.
- `row_done`  out  1  current address is the last column of a patch row.
- `patch_done`  out  1  sticky; the whole patch has been written.
- `invalid_addr`  out  1  current address lies outside the image.
- `data_out`  out  DATA_WIDTH  FIFO read data, registered.
- `full`  out  1  FIFO full.
- `empty`  out  1  FIFO empty.

## Operation
**Counters**
- `col_cnt` runs 0..2pc.
- `row_cnt` runs 0..2pr.
- `row_base` accumulates row_cnt·cols by repeated addition of `cols`; there is no multiplier.

**Address**
- `addr` = start_address + row_base + col_cnt.
- `addr` is combinational from the counters and `start_address`, truncated to imbits.

**Invalid address**
- `invalid_addr` is 1 when the (imbits+1)-bit sum start_address + row_base + col_cnt ≥ rows·cols.
- Otherwise `invalid_addr` is 0.

**Advance condition**
- Advance occurs when addr_en & col_count_en & !patch_done.
- `col_cnt` increments on advance.
- When col_cnt = 2pc, `col_cnt` wraps to 0, `row_cnt` increments and `row_base` += cols.

**Done flags**
- `row_done` = (col_cnt = 2pc) & addr_en.
- On the advance at (row_cnt = 2pr, col_cnt = 2pc), `patch_done` is set and the counters freeze.

**FIFO write**
- Each advance is one internal FIFO write.
- The written data is `pixel_in` when valid, and 0 when `invalid_addr` (zero padding).
- Every patch therefore yields exactly (2pr+1)(2pc+1) entries: 1089 at defaults.

**Re-arm**
- With addr_en = 0, the counters clear to 0 and `patch_done` clears.
- `start_address` is sampled combinationally, so it must be held stable while addr_en = 1.

**FIFO**
- The FIFO uses read/write pointers of log2(DEPTH)+1 bits.
- `empty` is asserted when the pointers are equal.
- `full` is asserted when the MSBs differ and the remaining bits are equal.
- A write when full is dropped.
- A read when empty is ignored and `data_out` holds its value.
- A simultaneous read and write is allowed in any non-degenerate state.

## Timing
**Reset values**
- Counters, `row_base` and both FIFO pointers are 0.
- `patch_done` = 0.
- `data_out` = 0.
- `empty` = 1 and `full` = 0.
- `addr` = start_address, because it is combinational.

**Generator timing**
- Throughput is one pixel per clock.
- First advance is at the first edge with addr_en & col_count_en high.
- `patch_done` rises at the edge of the 1089th write, i.e. 1089 advancing cycles after start.
- col_count_en = 0 stalls the generator with no write; `addr` is held.

**FIFO timing**
- Read latency is 1: `data_out` updates at the edge where r_en & !empty.
- `empty` and `full` update at the same edge as the pointer change.

**Reset mid-operation**
- Everything returns to the reset values on the next edge.
- Any FIFO contents are discarded.

## Test plan
- **Reset**: reset=1 for 2 cycles, start_address=0x100.
  - addr=0x100, patch_done=0, empty=1, full=0, data_out=0.
- **Interior patch**: r=117, c=195, defaults, addr_en=col_count_en=1.
  - First addr=101·1024+179=103603.
  - row_done every 33rd cycle.
  - patch_done after 1089 cycles.
  - Last addr=133·1024+211=136403.
  - FIFO holds 1089 entries matching image[r−16..r+16][c−16..c+16].
- **Stall**: toggle col_count_en 0/1 mid-row.
  - addr holds while 0.
  - FIFO count still ends at exactly 1089.
  - No duplicate entries.
- **Bottom edge**: start_address = 430·1024+100.
  - Rows whose address ≥ 446464 assert invalid_addr and are written as 0.
  - patch_done is still reached.
- **FIFO boundaries**: DEPTH=16, write 16 entries.
  - full=1; a 17th write is dropped.
  - Read 16 entries: data is returned in order, with one-cycle latency; then empty=1.
  - A read while empty leaves data_out unchanged.
- **Re-arm**: after patch_done, drop addr_en for 1 cycle, change start_address and re-assert.
  - Counters restart at 0, patch_done clears, and a second 1089-entry patch is produced.
